// File: rtl/fifodcx_pkg.sv
// Shared constants and types for the FIFO read-side word packer.
package fifodcx_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int FIFO_RD_LAT      = 1;
  localparam int DEF_WORD_NIBBLES = 4;
  localparam int DEF_WORD_W       = DEF_WORD_NIBBLES * NIBBLE_W;

  typedef enum logic [1:0] {
    STREAM  = 2'd0,
    REWIND1 = 2'd1,
    REWIND2 = 2'd2
  } rd_state_e;

  function automatic int word_w(input int nibbles);
    return nibbles * NIBBLE_W;
  endfunction

endpackage

// File: rtl/fifodcx_word_outreg.sv
// One-entry output register with valid/ready handshake and accepted-word counter.
module fifodcx_word_outreg #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_free,
  output logic [CNT_W-1:0]  o_count
);

  logic [WORD_W-1:0] r_data;
  logic              r_valid;
  logic [CNT_W-1:0]  r_count;
  logic              w_accept;

  assign w_accept = r_valid && i_ready;
  // Free this cycle if empty, or if the held word leaves on this edge.
  assign o_free   = !r_valid || i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_load) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_accept) r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/fifodcx_rd_word_packer.sv
// Pops nibbles from the dual-clock FIFO read port and packs them LSB-first into
// words; owns RdEn and the read-pointer reset used for replay.
module fifodcx_rd_word_packer
  import fifodcx_pkg::*;
#(
  parameter int WORD_NIBBLES = 4,
  parameter int RD_LATENCY   = 1,
  parameter int CNT_W        = 16
) (
  input  logic                             RdClock,
  input  logic                             Reset,
  input  logic [NIBBLE_W-1:0]              FifoQ,
  input  logic                             Empty,
  input  logic                             AlmostEmpty,
  output logic                             RdEn,
  output logic                             RPReset,
  input  logic                             Rewind,
  output logic [WORD_NIBBLES*NIBBLE_W-1:0] WordOut,
  output logic                             WordValid,
  input  logic                             WordReady,
  output logic [CNT_W-1:0]                 WordCount,
  output logic                             LowWater
);

  localparam int              WORD_W  = word_w(WORD_NIBBLES);
  localparam int              NC_W    = $clog2(WORD_NIBBLES + 1);
  localparam logic [NC_W-1:0] NC_FULL = NC_W'(WORD_NIBBLES);

  if (RD_LATENCY != FIFO_RD_LAT) begin : g_lat_chk
    $error("fifodcx_rd_word_packer supports RD_LATENCY=1 only");
  end

  rd_state_e                            r_state, w_state_nxt;
  logic [WORD_NIBBLES-1:0][NIBBLE_W-1:0] r_asm;
  logic [NC_W-1:0]                      r_nib_cnt;
  logic                                 r_pend, r_rpreset, r_low;
  logic                                 w_rewind_go, w_full, w_free, w_xfer;

  always_ff @(posedge RdClock or posedge Reset) begin
    if (Reset) r_state <= STREAM;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STREAM:  if (Rewind) w_state_nxt = REWIND1;
      REWIND1: w_state_nxt = REWIND2;
      REWIND2: w_state_nxt = STREAM;
      default: w_state_nxt = STREAM;
    endcase
  end

  assign w_rewind_go = (r_state == STREAM) && Rewind;
  assign w_full      = (r_nib_cnt == NC_FULL);
  // A rewind wipes the assembly register, so it also blocks the transfer.
  assign w_xfer      = w_full && w_free && !w_rewind_go;

  // Counting the in-flight read keeps the assembler from ever overfilling.
  assign RdEn = !Reset && (r_state == STREAM) && !Empty && !Rewind &&
                ((r_nib_cnt + NC_W'(r_pend)) < NC_FULL);

  always_ff @(posedge RdClock or posedge Reset) begin
    if (Reset) begin
      r_asm     <= '0;
      r_nib_cnt <= '0;
      r_pend    <= 1'b0;
      r_rpreset <= 1'b0;
      r_low     <= 1'b0;
    end else begin
      r_rpreset <= (w_state_nxt != STREAM);
      r_low     <= AlmostEmpty;
      if (w_rewind_go) begin
        r_asm     <= '0;
        r_nib_cnt <= '0;
        r_pend    <= 1'b0;
      end else begin
        r_pend <= RdEn;
        if (r_pend) begin
          for (int i = 0; i < WORD_NIBBLES; i++)
            if (r_nib_cnt == NC_W'(i)) r_asm[i] <= FifoQ;
          r_nib_cnt <= r_nib_cnt + NC_W'(1);
        end else if (w_xfer) begin
          r_nib_cnt <= '0;
        end
      end
    end
  end

  fifodcx_word_outreg #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_outreg (
    .clk     (RdClock),
    .rst     (Reset),
    .i_load  (w_xfer),
    .i_data  (r_asm),
    .i_ready (WordReady),
    .o_data  (WordOut),
    .o_valid (WordValid),
    .o_free  (w_free),
    .o_count (WordCount)
  );

  assign RPReset  = r_rpreset;
  assign LowWater = r_low;

endmodule
